c3aibadapt_avmm_chain_arb: RTL and testbench
============================================

Name: c3aibadapt_avmm_chain_arb

Overview:
Two-master arbiter sharing the per-channel Avalon-MM config bus that is daisy-chained through the AIB channel routing. Master 0 is the core CSR master; master 1 is the DFT/test master. The arbiter accepts one command at a time, round-robin. It drives the command onto the chain and holds it until the chain accepts it. For reads it waits for read data and returns it to the owning master.

Parameters:
ADDR_W, 17, address width
DATA_W, 32, data width
TIMEOUT_CYC, 255, cycles before abort (used only with the optional feature)
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout abort

Ports:
i_clk  input  1  config bus clock
i_rst_n  input  1  asynchronous active-low reset
i_m0_addr / i_m1_addr  input  ADDR_W  master address
i_m0_byte_en / i_m1_byte_en  input  4  master byte enables
i_m0_read / i_m1_read  input  1  master read request
i_m0_write / i_m1_write  input  1  master write request
i_m0_wdata / i_m1_wdata  input  DATA_W  master write data
o_m0_rdata / o_m1_rdata  output  DATA_W  read data to master
o_m0_rdatavalid / o_m1_rdatavalid  output  1  one-cycle read-data strobe
o_m0_waitreq / o_m1_waitreq  output  1  master command stall
o_addr, o_byte_en, o_wdata  output  ADDR_W/4/DATA_W  registered command to chain
o_read, o_write  output  1  registered command strobes to chain
i_rdata  input  DATA_W  chain read data
i_rdatavalid  input  1  chain read-data strobe
i_waitreq  input  1  chain command stall
o_err_spurious  output  1  sticky flag: i_rdatavalid seen outside WAIT_RD
o_timeout  output  1  sticky flag: timeout abort occurred

Behaviour:
- Reset values: o_mN_waitreq=1, all other outputs 0, state=IDLE, last_grant=1 (so m0 wins first).
- Request: reqN = i_mN_read | i_mN_write. If both read and write are set, the command is treated as a write.
- IDLE:
  - Arbitration:
    - Single request: grant that master.
    - Both request: grant the master that is not last_grant.
  - The granted master's o_mN_waitreq is 0 combinationally in that cycle. The command is accepted (posted) then.
  - Next edge: latch addr/byte_en/wdata/read/write into o_* registers, update last_grant, go ISSUE.
  - The non-granted master sees waitreq=1.
- ISSUE:
  - o_read/o_write are held until a cycle with i_waitreq=0.
  - On that edge: clear o_read/o_write. A write goes to IDLE; a read goes to WAIT_RD.
  - Command accept latency is ≥1 cycle after grant.
- WAIT_RD:
  - On i_rdatavalid=1, register i_rdata to the owning master's o_mN_rdata.
  - Pulse o_mN_rdatavalid for exactly 1 cycle (one cycle after i_rdatavalid), then return to IDLE.
  - The other master's rdata and rdatavalid are unchanged.
- Both o_mN_waitreq are 1 in every state other than IDLE. At most one command is outstanding.
- o_mN_rdata holds its last value until the next read completes for that master.
- i_rdatavalid in IDLE or ISSUE is ignored and sets o_err_spurious. Sticky flags clear only on reset.
- A grant can occur in the cycle after a return to IDLE. Back-to-back throughput is one command per 2 cycles for writes with i_waitreq=0.
- An asynchronous reset mid-transaction returns to reset values immediately. The in-flight command is dropped and the master is not notified.

Optional Feature:
Macro C3AIBADAPT_AVMM_ARB_TIMEOUT_EN.
- Enabled:
  - An 8+ bit counter clears on entry to ISSUE and to WAIT_RD and increments each cycle in those states.
  - When it reaches TIMEOUT_CYC, the arbiter aborts:
    - ISSUE: clear o_read/o_write.
    - Read aborts: return ERR_DATA with a one-cycle rdatavalid to the owner.
    - Set o_timeout, go IDLE.
- Disabled: no counter, waits indefinitely, o_timeout tied 0.

Test Plan:
- Write: m0 write addr=0x00123, wdata=0xA5A5_0001, i_waitreq=0 → o_m0_waitreq=0 same cycle; o_write=1 for 1 cycle with matching addr/data; o_m1_* untouched.
- Read: m1 read 0x1FFFF, chain returns i_rdata=0x1234_5678 three cycles after accept → o_m1_rdata=0x1234_5678, o_m1_rdatavalid 1-cycle pulse one cycle after i_rdatavalid.
- Contention: both masters request writes continuously → grants alternate m0, m1, m0, m1; neither master starves.
- Chain stall: i_waitreq=1 for 10 cycles during a write → o_write and command held stable 10 cycles, both o_mN_waitreq=1, single transfer completes after i_waitreq falls.
- Spurious/reset: i_rdatavalid pulse in IDLE → o_err_spurious=1 and sticky; i_rst_n low during WAIT_RD → all outputs at reset values, o_mN_waitreq=1.
- Timeout (macro on): read with no i_rdatavalid → after 255 cycles in WAIT_RD, o_m0_rdata=0xDEAD_BEEF with rdatavalid pulse, o_timeout=1, next request granted.

Source files
------------

// File: rtl/c3aibadapt_avmm_chain_arb.sv
// Round-robin two-master arbiter for the daisy-chained per-channel Avalon-MM config bus.
// Optional command/read timeout abort is enabled by defining C3AIBADAPT_AVMM_ARB_TIMEOUT_EN.
module c3aibadapt_avmm_chain_arb #(
  parameter int                ADDR_W      = 17,
  parameter int                DATA_W      = 32,
  parameter int                TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [3:0]        i_m0_byte_en,
  input  logic              i_m0_read,
  input  logic              i_m0_write,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic              o_m0_rdatavalid,
  output logic              o_m0_waitreq,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [3:0]        i_m1_byte_en,
  input  logic              i_m1_read,
  input  logic              i_m1_write,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_m1_rdatavalid,
  output logic              o_m1_waitreq,
  output logic [ADDR_W-1:0] o_addr,
  output logic [3:0]        o_byte_en,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_read,
  output logic              o_write,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_rdatavalid,
  input  logic              i_waitreq,
  output logic              o_err_spurious,
  output logic              o_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_last_grant;
  logic r_owner;
  logic w_req0;
  logic w_req1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_gnt_any;
  logic w_tmo;

  logic [ADDR_W-1:0] w_sel_addr;
  logic [3:0]        w_sel_byte_en;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_write;
  logic              w_sel_read;

  assign w_req0 = i_m0_read | i_m0_write;
  assign w_req1 = i_m1_read | i_m1_write;

  // Grant only in IDLE; on contention the master that did not win last time goes next.
  // Gating with reset keeps both masters stalled while reset is held.
  assign w_gnt0 = i_rst_n & (r_state == ST_IDLE) & w_req0 & (~w_req1 | r_last_grant);
  assign w_gnt1 = i_rst_n & (r_state == ST_IDLE) & w_req1 & (~w_req0 | ~r_last_grant);
  assign w_gnt_any = w_gnt0 | w_gnt1;

  assign o_m0_waitreq = ~w_gnt0;
  assign o_m1_waitreq = ~w_gnt1;

  assign w_sel_addr    = w_gnt1 ? i_m1_addr    : i_m0_addr;
  assign w_sel_byte_en = w_gnt1 ? i_m1_byte_en : i_m0_byte_en;
  assign w_sel_wdata   = w_gnt1 ? i_m1_wdata   : i_m0_wdata;
  assign w_sel_write   = w_gnt1 ? i_m1_write   : i_m0_write;
  // Write wins when a master raises read and write together.
  assign w_sel_read    = (w_gnt1 ? i_m1_read : i_m0_read) & ~w_sel_write;

`ifdef C3AIBADAPT_AVMM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  assign w_tmo     = (r_state != ST_IDLE) & (r_cnt == CNT_W'(TIMEOUT_CYC));
  assign o_timeout = r_timeout;

  // Cycles spent in the current ISSUE or WAIT_RD visit; restarts on every entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if ((w_state_nxt != r_state) && (w_state_nxt != ST_IDLE)) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_state != ST_IDLE) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timeout <= 1'b0;
    end else if (w_tmo && !((r_state == ST_ISSUE) && !i_waitreq)
                       && !((r_state == ST_WAIT_RD) && i_rdatavalid)) begin
      r_timeout <= 1'b1;
    end else begin
      r_timeout <= r_timeout;
    end
  end
`else
  logic w_unused_cfg;

  assign w_tmo        = 1'b0;
  assign o_timeout    = 1'b0;
  assign w_unused_cfg = (^ERR_DATA) ^ TIMEOUT_CYC[0];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_any) begin
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!i_waitreq) begin
          w_state_nxt = o_read ? ST_WAIT_RD : ST_IDLE;
        end else if (w_tmo) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_WAIT_RD: begin
        if (i_rdatavalid || w_tmo) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_RD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant    <= 1'b1;
      r_owner         <= 1'b0;
      o_addr          <= {ADDR_W{1'b0}};
      o_byte_en       <= 4'h0;
      o_wdata         <= {DATA_W{1'b0}};
      o_read          <= 1'b0;
      o_write         <= 1'b0;
      o_m0_rdata      <= {DATA_W{1'b0}};
      o_m1_rdata      <= {DATA_W{1'b0}};
      o_m0_rdatavalid <= 1'b0;
      o_m1_rdatavalid <= 1'b0;
      o_err_spurious  <= 1'b0;
    end else begin
      o_m0_rdatavalid <= 1'b0;
      o_m1_rdatavalid <= 1'b0;
      if (i_rdatavalid && (r_state != ST_WAIT_RD)) begin
        o_err_spurious <= 1'b1;
      end else begin
        o_err_spurious <= o_err_spurious;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_any) begin
            o_addr       <= w_sel_addr;
            o_byte_en    <= w_sel_byte_en;
            o_wdata      <= w_sel_wdata;
            o_write      <= w_sel_write;
            o_read       <= w_sel_read;
            r_owner      <= w_gnt1;
            r_last_grant <= w_gnt1;
          end else begin
            o_read  <= 1'b0;
            o_write <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (!i_waitreq) begin
            o_read  <= 1'b0;
            o_write <= 1'b0;
          end else if (w_tmo) begin
            // Aborted read still owes its master a response.
            o_read  <= 1'b0;
            o_write <= 1'b0;
            if (o_read && r_owner) begin
              o_m1_rdata      <= ERR_DATA;
              o_m1_rdatavalid <= 1'b1;
            end else if (o_read) begin
              o_m0_rdata      <= ERR_DATA;
              o_m0_rdatavalid <= 1'b1;
            end else begin
              o_m0_rdatavalid <= 1'b0;
            end
          end else begin
            o_read  <= o_read;
            o_write <= o_write;
          end
        end
        ST_WAIT_RD: begin
          if (i_rdatavalid || w_tmo) begin
            if (r_owner) begin
              o_m1_rdata      <= i_rdatavalid ? i_rdata : ERR_DATA;
              o_m1_rdatavalid <= 1'b1;
            end else begin
              o_m0_rdata      <= i_rdatavalid ? i_rdata : ERR_DATA;
              o_m0_rdatavalid <= 1'b1;
            end
          end else begin
            o_m0_rdata <= o_m0_rdata;
          end
        end
        default: begin
          o_read  <= 1'b0;
          o_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c3aibadapt_avmm_chain_arb.sv
// Directed self-checking bench for c3aibadapt_avmm_chain_arb.
// Timeout checks run only when C3AIBADAPT_AVMM_ARB_TIMEOUT_EN is defined.
module tb_c3aibadapt_avmm_chain_arb;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;

  logic              i_clk;
  logic              i_rst_n;
  logic [ADDR_W-1:0] i_m0_addr;
  logic [3:0]        i_m0_byte_en;
  logic              i_m0_read;
  logic              i_m0_write;
  logic [DATA_W-1:0] i_m0_wdata;
  logic [DATA_W-1:0] o_m0_rdata;
  logic              o_m0_rdatavalid;
  logic              o_m0_waitreq;
  logic [ADDR_W-1:0] i_m1_addr;
  logic [3:0]        i_m1_byte_en;
  logic              i_m1_read;
  logic              i_m1_write;
  logic [DATA_W-1:0] i_m1_wdata;
  logic [DATA_W-1:0] o_m1_rdata;
  logic              o_m1_rdatavalid;
  logic              o_m1_waitreq;
  logic [ADDR_W-1:0] o_addr;
  logic [3:0]        o_byte_en;
  logic [DATA_W-1:0] o_wdata;
  logic              o_read;
  logic              o_write;
  logic [DATA_W-1:0] i_rdata;
  logic              i_rdatavalid;
  logic              i_waitreq;
  logic              o_err_spurious;
  logic              o_timeout;

  int n_checks = 0;
  int n_errors = 0;

  c3aibadapt_avmm_chain_arb #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_m0_addr(i_m0_addr), .i_m0_byte_en(i_m0_byte_en), .i_m0_read(i_m0_read),
    .i_m0_write(i_m0_write), .i_m0_wdata(i_m0_wdata), .o_m0_rdata(o_m0_rdata),
    .o_m0_rdatavalid(o_m0_rdatavalid), .o_m0_waitreq(o_m0_waitreq),
    .i_m1_addr(i_m1_addr), .i_m1_byte_en(i_m1_byte_en), .i_m1_read(i_m1_read),
    .i_m1_write(i_m1_write), .i_m1_wdata(i_m1_wdata), .o_m1_rdata(o_m1_rdata),
    .o_m1_rdatavalid(o_m1_rdatavalid), .o_m1_waitreq(o_m1_waitreq),
    .o_addr(o_addr), .o_byte_en(o_byte_en), .o_wdata(o_wdata),
    .o_read(o_read), .o_write(o_write),
    .i_rdata(i_rdata), .i_rdatavalid(i_rdatavalid), .i_waitreq(i_waitreq),
    .o_err_spurious(o_err_spurious), .o_timeout(o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bit seen;
    i_rst_n = 1'b0;
    i_m0_addr = '0; i_m0_byte_en = 4'h0; i_m0_read = 1'b0; i_m0_write = 1'b0; i_m0_wdata = '0;
    i_m1_addr = '0; i_m1_byte_en = 4'h0; i_m1_read = 1'b0; i_m1_write = 1'b0; i_m1_wdata = '0;
    i_rdata = '0; i_rdatavalid = 1'b0; i_waitreq = 1'b0;
    tick();
    tick();
    chk("rst_m0_waitreq", o_m0_waitreq, 1);
    chk("rst_m1_waitreq", o_m1_waitreq, 1);
    chk("rst_write", o_write, 0);
    chk("rst_read", o_read, 0);
    chk("rst_spurious", o_err_spurious, 0);
    chk("rst_timeout", o_timeout, 0);
    i_rst_n = 1'b1;
    tick();

    // m0 write
    i_m0_addr = 17'h00123; i_m0_wdata = 32'hA5A5_0001; i_m0_byte_en = 4'hF; i_m0_write = 1'b1;
    #1;
    chk("wr_m0_waitreq_grant", o_m0_waitreq, 0);
    chk("wr_m1_waitreq_grant", o_m1_waitreq, 1);
    tick();
    i_m0_write = 1'b0;
    chk("wr_o_write", o_write, 1);
    chk("wr_o_read", o_read, 0);
    chk("wr_o_addr", o_addr, 17'h00123);
    chk("wr_o_wdata", o_wdata, 32'hA5A5_0001);
    chk("wr_o_byte_en", o_byte_en, 4'hF);
    chk("wr_m0_waitreq_issue", o_m0_waitreq, 1);
    tick();
    chk("wr_o_write_clear", o_write, 0);
    chk("wr_m1_rdatavalid", o_m1_rdatavalid, 0);
    chk("wr_m1_rdata", o_m1_rdata, 0);

    // m1 read
    i_m1_addr = 17'h1FFFF; i_m1_byte_en = 4'h3; i_m1_read = 1'b1;
    #1;
    chk("rd_m1_waitreq_grant", o_m1_waitreq, 0);
    tick();
    i_m1_read = 1'b0;
    chk("rd_o_read", o_read, 1);
    chk("rd_o_addr", o_addr, 17'h1FFFF);
    chk("rd_o_byte_en", o_byte_en, 4'h3);
    tick();
    chk("rd_o_read_clear", o_read, 0);
    chk("rd_waitreq_wait", {o_m0_waitreq, o_m1_waitreq}, 2'b11);
    tick();
    tick();
    i_rdatavalid = 1'b1; i_rdata = 32'h1234_5678;
    #1;
    chk("rd_rdv_not_yet", o_m1_rdatavalid, 0);
    tick();
    i_rdatavalid = 1'b0; i_rdata = 32'h0;
    chk("rd_m1_rdatavalid", o_m1_rdatavalid, 1);
    chk("rd_m1_rdata", o_m1_rdata, 32'h1234_5678);
    chk("rd_m0_rdatavalid", o_m0_rdatavalid, 0);
    chk("rd_m0_rdata", o_m0_rdata, 0);
    tick();
    chk("rd_m1_rdatavalid_pulse", o_m1_rdatavalid, 0);
    chk("rd_m1_rdata_hold", o_m1_rdata, 32'h1234_5678);
    chk("rd_no_spurious", o_err_spurious, 0);

    // contention: both masters write continuously, grants alternate from m0
    i_m0_addr = 17'h00010; i_m0_wdata = 32'h0000_0A00; i_m0_write = 1'b1;
    i_m1_addr = 17'h00020; i_m1_wdata = 32'h0000_0B00; i_m1_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("arb_m0_waitreq", o_m0_waitreq, (i % 2 == 0) ? 1'b0 : 1'b1);
      chk("arb_m1_waitreq", o_m1_waitreq, (i % 2 == 0) ? 1'b1 : 1'b0);
      tick();
      chk("arb_o_addr", o_addr, (i % 2 == 0) ? 17'h00010 : 17'h00020);
      chk("arb_o_wdata", o_wdata, (i % 2 == 0) ? 32'h0000_0A00 : 32'h0000_0B00);
      tick();
    end
    i_m0_write = 1'b0; i_m1_write = 1'b0;

    // chain stall for 10 cycles
    i_waitreq = 1'b1;
    i_m0_addr = 17'h00555; i_m0_wdata = 32'hCAFE_0005; i_m0_write = 1'b1;
    #1;
    chk("stall_grant", o_m0_waitreq, 0);
    tick();
    i_m0_write = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_o_write", o_write, 1);
      chk("stall_o_addr", o_addr, 17'h00555);
      chk("stall_o_wdata", o_wdata, 32'hCAFE_0005);
      chk("stall_waitreq", {o_m0_waitreq, o_m1_waitreq}, 2'b11);
      tick();
    end
    i_waitreq = 1'b0;
    #1;
    chk("stall_o_write_last", o_write, 1);
    tick();
    chk("stall_o_write_done", o_write, 0);
    tick();
    chk("stall_single_xfer", o_write, 0);

    // spurious read data in IDLE
    i_rdatavalid = 1'b1; i_rdata = 32'h5555_AAAA;
    tick();
    i_rdatavalid = 1'b0;
    chk("spur_flag", o_err_spurious, 1);
    chk("spur_no_rdv", {o_m0_rdatavalid, o_m1_rdatavalid}, 2'b00);
    tick();
    tick();
    chk("spur_sticky", o_err_spurious, 1);

    // reset during WAIT_RD
    i_m0_addr = 17'h00042; i_m0_byte_en = 4'h1; i_m0_read = 1'b1;
    tick();
    i_m0_read = 1'b0;
    chk("rstrd_o_read", o_read, 1);
    tick();
    chk("rstrd_in_wait", {o_m0_waitreq, o_read}, 2'b10);
    i_rst_n = 1'b0;
    #1;
    chk("rstrd_waitreq", {o_m0_waitreq, o_m1_waitreq}, 2'b11);
    chk("rstrd_spurious", o_err_spurious, 0);
    chk("rstrd_m1_rdata", o_m1_rdata, 0);
    chk("rstrd_o_addr", o_addr, 0);
    chk("rstrd_o_byte_en", o_byte_en, 0);
    tick();
    i_rst_n = 1'b1;
    i_m0_addr = 17'h00077; i_m0_read = 1'b1; i_m1_addr = 17'h00088; i_m1_read = 1'b1;
    #1;
    chk("rstrd_m0_first", {o_m0_waitreq, o_m1_waitreq}, 2'b01);
    tick();
    i_m0_read = 1'b0; i_m1_read = 1'b0;
    chk("rstrd_rd_addr", o_addr, 17'h00077);

`ifdef C3AIBADAPT_AVMM_ARB_TIMEOUT_EN
    tick();
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!seen) begin
        if (o_m0_rdatavalid) begin
          seen = 1'b1;
          chk("tmo_rdata", o_m0_rdata, 32'hDEAD_BEEF);
          chk("tmo_flag", o_timeout, 1);
        end else begin
          tick();
        end
      end
    end
    chk("tmo_seen", seen, 1);
    tick();
    chk("tmo_pulse", o_m0_rdatavalid, 0);
    i_m1_write = 1'b1; i_m1_addr = 17'h00099;
    #1;
    chk("tmo_next_grant", o_m1_waitreq, 0);
    tick();
    i_m1_write = 1'b0;
`else
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (o_m0_rdatavalid) seen = 1'b1;
    end
    chk("notmo_no_abort", seen, 0);
    chk("notmo_flag", o_timeout, 0);
    chk("notmo_still_waiting", {o_m0_waitreq, o_m1_waitreq}, 2'b11);
    i_rdatavalid = 1'b1; i_rdata = 32'h0BAD_F00D;
    tick();
    i_rdatavalid = 1'b0;
    chk("notmo_late_rdv", o_m0_rdatavalid, 1);
    chk("notmo_late_rdata", o_m0_rdata, 32'h0BAD_F00D);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
